// File: rtl/half_norm_round.sv
// Iterative normalize, round and pack stage for the binary16 multiplier.
// Define HALF_NORM_ROUND_RNE_EN for round-to-nearest-even; default truncates.
module half_norm_round #(
    parameter int BIAS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [5:0]  exp,
    input  logic [20:0] frac_norm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              sign_q;
    logic [20:0]       f_q;
    logic signed [7:0] e_q;

    logic              f_zero;
    logic              norm_done;
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic              inexact;
    logic [9:0]        mant_r;
    logic signed [7:0] e_r;
    logic              is_ovf;
    logic              is_unf;
    logic              is_norm;
    logic [15:0]       pack_data;
    logic [2:0]        pack_flags;

    assign f_zero    = (f_q == 21'd0);
    assign norm_done = f_q[20] || f_zero;
    assign in_ready  = (state_q == IDLE) && !rst;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_valid) state_d = NORM;
            NORM:  if (norm_done) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
        endcase
    end

    assign mant    = f_q[19:10];
    assign guard   = f_q[9];
    assign sticky  = |f_q[8:0];
    assign inexact = guard | sticky;

`ifdef HALF_NORM_ROUND_RNE_EN
    logic        round_up;
    logic [10:0] mant_sum;

    assign round_up = guard & (sticky | mant[0]);
    assign mant_sum = {1'b0, mant} + 11'(round_up);
    // A carry out leaves mant_sum[9:0] at zero and bumps the exponent
    assign mant_r   = mant_sum[9:0];
    assign e_r      = e_q + 8'(mant_sum[10]);
`else
    assign mant_r   = mant;
    assign e_r      = e_q;
`endif

    assign is_ovf  = !f_zero && (e_r >= 8'sd31);
    assign is_unf  = !f_zero && (e_r <= 8'sd0);
    assign is_norm = !f_zero && !is_ovf && !is_unf;

    always_comb begin
        pack_data  = {sign_q, 15'h0000};
        pack_flags = 3'b000;
        unique case (1'b1)
            f_zero: begin
                pack_data  = {sign_q, 15'h0000};
                pack_flags = 3'b000;
            end
            is_ovf: begin
                pack_data  = {sign_q, 5'h1F, 10'h000};
                pack_flags = 3'b101;
            end
            is_unf: begin
                pack_data  = {sign_q, 15'h0000};
                pack_flags = 3'b011;
            end
            is_norm: begin
                pack_data  = {sign_q, e_r[4:0], mant_r};
                pack_flags = {2'b00, inexact};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            f_q       <= 21'd0;
            e_q       <= 8'sd0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_flags <= 3'b000;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sign;
                        f_q    <= frac_norm;
                        e_q    <= {2'b00, exp} - 8'(BIAS) + 8'd1;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        f_q <= f_q << 1;
                        e_q <= e_q - 8'sd1;
                    end
                end
                ROUND: begin
                    out_valid <= 1'b1;
                    out_data  <= pack_data;
                    out_flags <= pack_flags;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
